// File: rtl/msp_pkg.sv
// Shared MSP UART definitions: serializer state encoding and default bit timing.
package msp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_tx_state_t;

  // 72 MHz / 115200 baud
  localparam int unsigned MSP_UART_CLKS_PER_BIT = 625;

endpackage

// File: rtl/msp_uart_tx_if.sv
// Valid/ready byte stream from the MSP response framer to the UART transmitter.
interface msp_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/msp_byte_fifo.sv
// Synchronous show-ahead FIFO; push when full and pop when empty are ignored.
module msp_byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/msp_uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serializer.
module msp_uart_tx
  import msp_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = MSP_UART_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  msp_uart_tx_if.slave                  tx,
  output logic                          uart_txd,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_tx_state_t state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shift_reg, shift_n;
  logic           txd_n;
  logic           pop;
  logic           done;
  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_rdata;

  assign tx.tx_ready = !fifo_full && !rst;
  assign frame_done  = done && !rst;
  assign busy        = (state != S_IDLE) || (fifo_level != '0);

  msp_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx.tx_valid && tx.tx_ready),
    .pop   (pop),
    .wdata (tx.tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_txd  <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
      uart_txd  <= txd_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    txd_n     = uart_txd;
    pop       = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_rdata;
          txd_n   = 1'b0;
          cnt_n   = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (cnt == LAST) begin
          txd_n     = shift_reg[0];
          bit_idx_n = '0;
          cnt_n     = '0;
          state_n   = S_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            txd_n   = 1'b1;
            state_n = S_STOP;
          end else begin
            shift_n   = shift_reg >> 1;
            txd_n     = shift_reg[1];
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == LAST) begin
          done  = 1'b1;
          cnt_n = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_rdata;
            txd_n   = 1'b0;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_msp_uart_tx.sv
// Scoreboard bench for msp_uart_tx: a line monitor decodes frames against queued bytes.
module tb_msp_uart_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_seen = 1'b0;
  always @(posedge clk) if (rst) rst_seen = 1'b1;

  msp_uart_tx_if bus4 ();
  msp_uart_tx_if bus32 ();

  logic [7:0] t_data  = '0;
  logic       t_valid = 1'b0;
  logic       sel     = 1'b0;

  assign bus4.tx_data   = t_data;
  assign bus4.tx_valid  = t_valid && !sel;
  assign bus32.tx_data  = t_data;
  assign bus32.tx_valid = t_valid && sel;

  logic       txd4, fd4, busy4;
  logic [2:0] lvl4;
  logic       txd32, fd32, busy32;
  logic [5:0] lvl32;

  msp_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx         (bus4),
    .uart_txd   (txd4),
    .frame_done (fd4),
    .fifo_level (lvl4),
    .busy       (busy4)
  );

  msp_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(32)) dut32 (
    .clk        (clk),
    .rst        (rst),
    .tx         (bus32),
    .uart_txd   (txd32),
    .frame_done (fd32),
    .fifo_level (lvl32),
    .busy       (busy32)
  );

  logic        m_txd, m_fd, m_busy, m_ready;
  logic [31:0] m_level;
  assign m_txd   = sel ? txd32 : txd4;
  assign m_fd    = sel ? fd32 : fd4;
  assign m_busy  = sel ? busy32 : busy4;
  assign m_ready = sel ? bus32.tx_ready : bus4.tx_ready;
  assign m_level = sel ? 32'(lvl32) : 32'(lvl4);

  logic [7:0] exp_q [$];
  logic [7:0] rx_log [$];
  int         starts [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         stalls   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line monitor: samples mid-bit; a reset during a frame discards it.
  initial begin : monitor
    logic [7:0] b;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && m_txd === 1'b0) begin
        starts.push_back(cyc);
        rst_seen = 1'b0;
        b        = '0;
        aborted  = 1'b0;
        for (int c = 1; c < 40; c++) begin
          @(negedge clk);
          if (rst || rst_seen) begin
            aborted = 1'b1;
            break;
          end
          if (c == 2) chk("start_bit", 32'(m_txd), 0);
          if (c >= 6 && c <= 34 && (c - 6) % 4 == 0) b[(c-6)/4] = m_txd;
          if (c == 38) chk("stop_bit", 32'(m_txd), 1);
          chk("frame_done", 32'(m_fd), (c == 39) ? 1 : 0);
        end
        if (!aborted) begin
          rx_log.push_back(b);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_byte: got 0x%0h, expected no frame", b);
          end else begin
            chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, output int acc);
    int n;
    t_data  = b;
    t_valid = 1'b1;
    n       = 0;
    while (m_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      stalls++;
    end
    if (n >= 200) begin
      chk("push_timeout", 32'(n), 0);
      acc = -1;
    end else begin
      @(posedge clk);
      exp_q.push_back(b);
      #1 acc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((m_busy !== 1'b0 || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 2000), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         a;
    int         a0;
    int         lows;
    logic [7:0] x;
    logic [7:0] frame [22];

    frame = '{8'h24, 8'h4D, 8'h3E, 8'h10, 8'h6C,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10,
              8'h6C};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(m_txd), 1);
    chk("rst_frame_done", 32'(m_fd), 0);
    chk("rst_level", m_level, 0);
    chk("rst_busy", 32'(m_busy), 0);
    chk("rst_ready", 32'(m_ready), 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", 32'(m_ready), 1);
    @(negedge clk);

    // Single byte
    starts.delete();
    push_byte(8'h24, a);
    t_valid = 1'b0;
    wait_cyc(a + 40);
    chk("s1_busy_last_stop", 32'(m_busy), 1);
    @(negedge clk);
    chk("s1_busy_after", 32'(m_busy), 0);
    chk("s1_frames", 32'(starts.size()), 1);
    if (starts.size() > 0) chk("s1_start_cycle", 32'(starts[0]), 32'(a + 1));
    wait_idle("s1_drain");

    // Back-to-back
    starts.delete();
    push_byte(8'h24, a);
    push_byte(8'h4D, a);
    push_byte(8'h3E, a);
    t_valid = 1'b0;
    wait_idle("s2_drain");
    chk("s2_frames", 32'(starts.size()), 3);
    if (starts.size() == 3) begin
      chk("s2_gap1", 32'(starts[1] - starts[0]), 40);
      chk("s2_gap2", 32'(starts[2] - starts[1]), 40);
    end

    // Fill with valid held
    starts.delete();
    for (int i = 1; i <= 5; i++) push_byte(8'(i), a);
    chk("s3_ready_low", 32'(m_ready), 0);
    chk("s3_level_full", m_level, 4);
    push_byte(8'h06, a);
    t_valid = 1'b0;
    if (starts.size() > 0) chk("s3_ready_return", 32'(a), 32'(starts[0] + 41));
    wait_idle("s3_drain");
    chk("s3_frames", 32'(starts.size()), 6);

    // Push coinciding with a stop-bit pop
    push_byte(8'h11, a0);
    push_byte(8'h22, a);
    push_byte(8'h33, a);
    t_valid = 1'b0;
    wait_cyc(a0 + 40);
    chk("s4_level_before", m_level, 2);
    push_byte(8'h44, a);
    t_valid = 1'b0;
    chk("s4_accept_cycle", 32'(a), 32'(a0 + 41));
    chk("s4_level_after", m_level, 2);
    wait_idle("s4_drain");

    // Reset during bit 3 of 0xA5
    push_byte(8'hA5, a0);
    push_byte(8'hB6, a);
    push_byte(8'hC7, a);
    t_valid = 1'b0;
    wait_cyc(a0 + 1 + 17);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("s5_ready_in_rst", 32'(m_ready), 0);
    rst = 1'b0;
    chk("s5_txd", 32'(m_txd), 1);
    chk("s5_level", m_level, 0);
    chk("s5_busy", 32'(m_busy), 0);
    starts.delete();
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (m_txd !== 1'b1) lows++;
    end
    chk("s5_line_quiet", 32'(lows), 0);
    chk("s5_no_start", 32'(starts.size()), 0);
    push_byte(8'h5A, a);
    t_valid = 1'b0;
    wait_idle("s5_drain");

    // Maximum MSP frame through the 32-deep instance
    sel = 1'b1;
    @(negedge clk);
    rx_log.delete();
    stalls = 0;
    for (int i = 0; i < 22; i++) begin
      push_byte(frame[i], a);
      t_valid = 1'b0;
      @(negedge clk);
    end
    wait_idle("s6_drain");
    chk("s6_stalls", 32'(stalls), 0);
    chk("s6_bytes", 32'(rx_log.size()), 22);
    if (rx_log.size() == 22) begin
      x = '0;
      for (int i = 3; i <= 20; i++) x = x ^ rx_log[i];
      chk("s6_checksum_const", 32'(rx_log[21]), 32'h6C);
      chk("s6_checksum_xor", 32'(rx_log[21]), 32'(x));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
